// File: rtl/fpu_addsub_front.sv
// fpu_addsub_front: front half of a single-precision add/subtract unit.
// It unpacks both operands and aligns the smaller-exponent significand
// (keeping a sticky bit). It then adds or subtracts the magnitudes and
// emits an unnormalised 28-bit sum. A downstream post-normaliser takes
// that sum and handles rounding and inf/NaN.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   valid_i / ready_o    input handshake
//   opa_i, opb_i         IEEE-754 single operands
//   fpu_op_i             0 = add, 1 = subtract (opa - opb)
//   rmode_i              rounding mode (only used to sign an exact zero)
//   valid_o / ready_i    output handshake
//   fract_28_o           {carry, hidden, fraction[22:0], guard, round, sticky}
//   exp_o                exponent of the larger-exponent operand
//   sign_o               result sign
//   opa_o, opb_o, fpu_op_o, rmode_o  inputs delayed to line up with fract_28_o
//
// Two-stage pipeline: stage 1 holds the aligned operands and stage 2 holds
// the sum. Each stage advances when it is empty or when its consumer takes
// its data.
module fpu_addsub_front (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        fpu_op_i,
    input  logic [1:0]  rmode_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [27:0] fract_28_o,
    output logic [7:0]  exp_o,
    output logic        sign_o,
    output logic [31:0] opa_o,
    output logic [31:0] opb_o,
    output logic        fpu_op_o,
    output logic [1:0]  rmode_o
);

    // Handshake
    logic v1, v2;
    logic adv1, adv2;

    assign adv2    = !v2 || ready_i;
    assign adv1    = !v1 || adv2;
    assign ready_o = adv1;
    assign valid_o = v2;

    // Stage 1 combinational: unpack, compare, align
    logic [7:0]  ea, eb, diff;
    logic        ha, hb, a_big;
    logic [27:0] sig_a, sig_b, big_sig, small_sig, small_al, shift_mask;
    logic [4:0]  sh;
    logic        eff_sub, sign_b;

    always_comb begin
        ha         = |opa_i[30:23];
        hb         = |opb_i[30:23];
        ea         = ha ? opa_i[30:23] : 8'd1;
        eb         = hb ? opb_i[30:23] : 8'd1;
        sig_a      = {1'b0, ha, opa_i[22:0], 3'b000};
        sig_b      = {1'b0, hb, opb_i[22:0], 3'b000};
        a_big      = (ea >= eb);
        diff       = a_big ? (ea - eb) : (eb - ea);
        big_sig    = a_big ? sig_a : sig_b;
        small_sig  = a_big ? sig_b : sig_a;
        sh         = 5'd0;
        shift_mask = 28'd0;
        small_al   = small_sig;
        if (diff >= 8'd27) begin
            // Everything falls below bit 0; only the sticky survives.
            small_al = {27'b0, |small_sig[26:3]};
        end else begin
            sh         = diff[4:0];
            shift_mask = (28'd1 << sh) - 28'd1;
            small_al   = (small_sig >> sh) | {27'b0, |(small_sig & shift_mask)};
        end
        eff_sub = opa_i[31] ^ opb_i[31] ^ fpu_op_i;
        sign_b  = opb_i[31] ^ fpu_op_i;
    end

    // Stage 1 registers
    logic [27:0] s1_big, s1_small;
    logic [7:0]  s1_exp;
    logic        s1_a_big, s1_eff_sub, s1_sign_a, s1_sign_b, s1_op;
    logic [31:0] s1_opa, s1_opb;
    logic [1:0]  s1_rmode;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1         <= 1'b0;
            s1_big     <= 28'd0;
            s1_small   <= 28'd0;
            s1_exp     <= 8'd0;
            s1_a_big   <= 1'b0;
            s1_eff_sub <= 1'b0;
            s1_sign_a  <= 1'b0;
            s1_sign_b  <= 1'b0;
            s1_op      <= 1'b0;
            s1_opa     <= 32'd0;
            s1_opb     <= 32'd0;
            s1_rmode   <= 2'd0;
        end else if (adv1) begin
            v1 <= valid_i;
            if (valid_i) begin
                s1_big     <= big_sig;
                s1_small   <= small_al;
                s1_exp     <= a_big ? ea : eb;
                s1_a_big   <= a_big;
                s1_eff_sub <= eff_sub;
                s1_sign_a  <= opa_i[31];
                s1_sign_b  <= sign_b;
                s1_op      <= fpu_op_i;
                s1_opa     <= opa_i;
                s1_opb     <= opb_i;
                s1_rmode   <= rmode_i;
            end
        end
    end

    // Stage 2 combinational: add or subtract magnitudes
    logic [27:0] res;
    logic        res_sign;

    always_comb begin
        res      = 28'd0;
        res_sign = 1'b0;
        if (!s1_eff_sub) begin
            res      = s1_big + s1_small;
            res_sign = s1_sign_a;
        end else if (s1_big > s1_small) begin
            res      = s1_big - s1_small;
            res_sign = s1_a_big ? s1_sign_a : s1_sign_b;
        end else if (s1_small > s1_big) begin
            // Only reachable on an exponent tie where opb has the larger mantissa.
            res      = s1_small - s1_big;
            res_sign = s1_a_big ? s1_sign_b : s1_sign_a;
        end else begin
            // Exact cancellation: negative zero only when rounding toward -inf.
            res      = 28'd0;
            res_sign = (s1_rmode == 2'b11);
        end
    end

    // Stage 2 registers drive the outputs directly
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v2         <= 1'b0;
            fract_28_o <= 28'd0;
            exp_o      <= 8'd0;
            sign_o     <= 1'b0;
            opa_o      <= 32'd0;
            opb_o      <= 32'd0;
            fpu_op_o   <= 1'b0;
            rmode_o    <= 2'd0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                fract_28_o <= res;
                exp_o      <= s1_exp;
                sign_o     <= res_sign;
                opa_o      <= s1_opa;
                opb_o      <= s1_opb;
                fpu_op_o   <= s1_op;
                rmode_o    <= s1_rmode;
            end
        end
    end

endmodule

// File: tb/tb_fpu_addsub_front.sv
// Directed bench for fpu_addsub_front: hand-computed vectors, throughput,
// backpressure and asynchronous reset behaviour.
module tb_fpu_addsub_front;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] opa_i = 32'd0;
    logic [31:0] opb_i = 32'd0;
    logic        fpu_op_i = 1'b0;
    logic [1:0]  rmode_i = 2'd0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [27:0] fract_28_o;
    logic [7:0]  exp_o;
    logic        sign_o;
    logic [31:0] opa_o;
    logic [31:0] opb_o;
    logic        fpu_op_o;
    logic [1:0]  rmode_o;

    int checks = 0;
    int failures = 0;

    fpu_addsub_front dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .opa_i      (opa_i),
        .opb_i      (opb_i),
        .fpu_op_i   (fpu_op_i),
        .rmode_i    (rmode_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .fract_28_o (fract_28_o),
        .exp_o      (exp_o),
        .sign_o     (sign_o),
        .opa_o      (opa_o),
        .opb_o      (opb_o),
        .fpu_op_o   (fpu_op_o),
        .rmode_o    (rmode_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One transaction with ready_i high; result must appear exactly two edges later.
    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic op, input logic [1:0] rm, input logic [27:0] ef,
                           input logic [7:0] ee, input logic es);
        @(negedge clk_i);
        valid_i = 1'b1; opa_i = a; opb_i = b; fpu_op_i = op; rmode_i = rm;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        check({tag, "_early"}, {31'd0, valid_o}, 32'd0);
        @(posedge clk_i); #1;
        check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        check({tag, "_fract"}, {4'd0, fract_28_o}, {4'd0, ef});
        check({tag, "_exp"}, {24'd0, exp_o}, {24'd0, ee});
        check({tag, "_sign"}, {31'd0, sign_o}, {31'd0, es});
        check({tag, "_opa"}, opa_o, a);
        check({tag, "_opb"}, opb_o, b);
        check({tag, "_op"}, {30'd0, rmode_o, fpu_op_o}, {30'd0, rm, op});
    endtask

    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vop [3];
    logic [27:0] vf [3];
    logic [7:0]  ve [3];
    logic        vs [3];
    int          accepted;

    initial begin
        // Reset state
        #3;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_fract", {4'd0, fract_28_o}, 32'd0);
        check("rst_opa", opa_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        run_vec("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 28'h8000000, 8'h7F, 1'b0);
        run_vec("one_minus_one_rne", 32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 28'h0, 8'h7F, 1'b0);
        run_vec("one_minus_one_rdn", 32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 28'h0, 8'h7F, 1'b1);
        run_vec("one_minus_three", 32'h3F800000, 32'h40400000, 1'b1, 2'b00, 28'h4000000, 8'h80, 1'b1);
        run_vec("tiny_sticky", 32'h3F800000, 32'h30800000, 1'b0, 2'b00, 28'h4000001, 8'h7F, 1'b0);
        run_vec("denorm_add", 32'h00000001, 32'h00000001, 1'b0, 2'b00, 28'h0000010, 8'h01, 1'b0);
        run_vec("two_plus_neg_one", 32'h40000000, 32'hBF800000, 1'b0, 2'b01, 28'h2000000, 8'h80, 1'b0);
        run_vec("tie_b_larger", 32'h3F800000, 32'h3FC00000, 1'b1, 2'b10, 28'h2000000, 8'h7F, 1'b1);
        run_vec("shift24_sticky", 32'h3F800000, 32'h33800001, 1'b0, 2'b00, 28'h4000005, 8'h7F, 1'b0);

        // Back-to-back stream, one result per cycle
        va[0] = 32'h3F800000; vb[0] = 32'h3F800000; vop[0] = 1'b0;
        vf[0] = 28'h8000000;  ve[0] = 8'h7F;        vs[0] = 1'b0;
        va[1] = 32'h3F800000; vb[1] = 32'h40400000; vop[1] = 1'b1;
        vf[1] = 28'h4000000;  ve[1] = 8'h80;        vs[1] = 1'b1;
        va[2] = 32'h00000001; vb[2] = 32'h00000001; vop[2] = 1'b0;
        vf[2] = 28'h0000010;  ve[2] = 8'h01;        vs[2] = 1'b0;
        rmode_i = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (i >= 2) begin
                check("stream_valid", {31'd0, valid_o}, 32'd1);
                check("stream_fract", {4'd0, fract_28_o}, {4'd0, vf[i-2]});
                check("stream_sign", {31'd0, sign_o}, {31'd0, vs[i-2]});
            end
            check("stream_ready", {31'd0, ready_o}, 32'd1);
            valid_i = (i < 3);
            if (i < 3) begin
                opa_i = va[i]; opb_i = vb[i]; fpu_op_i = vop[i];
            end
        end
        @(negedge clk_i);
        check("stream_drain", {31'd0, valid_o}, 32'd0);

        // Backpressure: three back-to-back offers with ready_i low
        ready_i = 1'b0;
        accepted = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            valid_i = 1'b1; opa_i = va[i]; opb_i = vb[i]; fpu_op_i = vop[i];
            #1;
            if (ready_o) accepted++;
            @(posedge clk_i);
        end
        @(negedge clk_i);
        if (ready_o) accepted++;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        check("bp_accepted", accepted, 32'd2);
        check("bp_ready_low", {31'd0, ready_o}, 32'd0);
        check("bp_valid", {31'd0, valid_o}, 32'd1);
        check("bp_hold_fract", {4'd0, fract_28_o}, {4'd0, vf[0]});
        @(negedge clk_i);
        check("bp_stable_fract", {4'd0, fract_28_o}, {4'd0, vf[0]});
        check("bp_stable_exp", {24'd0, exp_o}, {24'd0, ve[0]});
        check("bp_stable_opb", opb_o, vb[0]);
        ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_second_valid", {31'd0, valid_o}, 32'd1);
        check("bp_second_fract", {4'd0, fract_28_o}, {4'd0, vf[1]});
        check("bp_second_exp", {24'd0, exp_o}, {24'd0, ve[1]});
        @(negedge clk_i);
        check("bp_empty", {31'd0, valid_o}, 32'd0);

        // Reset with both stages full
        ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            valid_i = 1'b1; opa_i = va[i]; opb_i = vb[i]; fpu_op_i = vop[i];
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        check("full_valid", {31'd0, valid_o}, 32'd1);
        check("full_ready", {31'd0, ready_o}, 32'd0);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_ready", {31'd0, ready_o}, 32'd1);
        check("arst_fract", {4'd0, fract_28_o}, 32'd0);
        check("arst_exp", {24'd0, exp_o}, 32'd0);
        check("arst_opa", opa_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("post_rst_no_stale", {31'd0, valid_o}, 32'd0);
        end
        run_vec("post_rst_denorm", 32'h00000001, 32'h00000001, 1'b0, 2'b00, 28'h0000010, 8'h01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
